stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 17 +
 rtl/stream_out_reg.sv | 35 +++
 rtl/stream_fifo.sv | 125 ++++++++++++
 tb/tb_stream_fifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// stream_fifo shared helpers.
// Depth and count-width arithmetic used by the FIFO and its users.
package stream_fifo_pkg;

    function automatic int fifo_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    function automatic int count_width(input int depth_bits);
        return depth_bits + 2;
    endfunction

    function automatic int afull_default(input int depth_bits);
        return (1 << depth_bits) - 2;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-entry valid/ready output register.
// Refills in the same cycle its current entry is taken.
module stream_out_reg
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised valid/ready FIFO with optional output
// register, occupancy count, almost flags and synchronous flush.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH_BITS   = 4,
    parameter int OUTPUT_REG   = 0,
    parameter int AFULL_LEVEL  = afull_default(DEPTH_BITS),
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic [DEPTH_BITS+1:0] count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int DEPTH = fifo_depth(DEPTH_BITS);
    localparam int CW    = count_width(DEPTH_BITS);

    typedef logic [DEPTH_BITS:0] ptr_t;
    typedef logic [CW-1:0]       count_t;

    localparam count_t AFULL_C  = count_t'(AFULL_LEVEL);
    localparam count_t AEMPTY_C = count_t'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    logic                  arr_empty;
    logic                  arr_full;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] head_data;

    assign arr_empty = wr_ptr == rd_ptr;
    assign arr_full  =
        (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]) &&
        (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]);

    assign input_ready = flush || !arr_full;
    assign push        = input_valid && !arr_full && !flush;
    assign pop         = output_valid && output_ready && !flush;
    assign head_data   = mem[rd_ptr[DEPTH_BITS-1:0]];

    generate
        if (OUTPUT_REG != 0) begin : g_reg
            logic                  reg_in_valid;
            logic                  reg_in_ready;
            logic [DATA_WIDTH-1:0] reg_in_data;

            // Empty array: the pushed word goes straight to the register.
            assign reg_in_valid = arr_empty ? push : 1'b1;
            assign reg_in_data  = arr_empty ? input_data : head_data;
            assign wr_en = push && !(arr_empty && reg_in_ready);
            assign rd_en = !arr_empty && reg_in_ready && !flush;

            stream_out_reg #(
                .DATA_WIDTH(DATA_WIDTH)
            ) u_out_reg (
                .clock    (clock),
                .reset_n  (reset_n),
                .flush    (flush),
                .in_valid (reg_in_valid),
                .in_ready (reg_in_ready),
                .in_data  (reg_in_data),
                .out_valid(output_valid),
                .out_ready(output_ready),
                .out_data (output_data)
            );
        end else begin : g_noreg
            assign wr_en        = push;
            assign rd_en        = pop;
            assign output_valid = !arr_empty;
            assign output_data  = head_data;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr[DEPTH_BITS-1:0]] <= input_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
            if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count <= count + count_t'(1);
                2'b01:   count <= count - count_t'(1);
                default: count <= count;
            endcase
        end
    end

    assign almost_full  = count >= AFULL_C;
    assign almost_empty = count <= AEMPTY_C;

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: vector tables, corner sequences and a queue-model
// random run on a depth-4 array FIFO and a depth-8 registered FIFO.
module tb_stream_fifo;

    logic        clock;
    logic        reset_n;
    logic        flush [2];
    logic        iv    [2];
    logic        ir    [2];
    logic [15:0] din   [2];
    logic        ov    [2];
    logic        ordy  [2];
    logic [15:0] dout  [2];
    logic        af    [2];
    logic        ae    [2];
    logic [3:0]  cnt_a;
    logic [4:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    stream_fifo #(
        .DATA_WIDTH(16),
        .DEPTH_BITS(2),
        .OUTPUT_REG(0)
    ) dut_a (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush[0]),
        .input_valid (iv[0]),
        .input_ready (ir[0]),
        .input_data  (din[0]),
        .output_valid(ov[0]),
        .output_ready(ordy[0]),
        .output_data (dout[0]),
        .count       (cnt_a),
        .almost_full (af[0]),
        .almost_empty(ae[0])
    );

    stream_fifo #(
        .DATA_WIDTH (16),
        .DEPTH_BITS (3),
        .OUTPUT_REG (1),
        .AFULL_LEVEL(6)
    ) dut_b (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush[1]),
        .input_valid (iv[1]),
        .input_ready (ir[1]),
        .input_data  (din[1]),
        .output_valid(ov[1]),
        .output_ready(ordy[1]),
        .output_data (dout[1]),
        .count       (cnt_b),
        .almost_full (af[1]),
        .almost_empty(ae[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          v;
        bit          rdy;
        logic [15:0] d;
        bit          e_ir;
        bit          e_ov;
        int          e_cnt;
        logic [15:0] e_dout;
    } vec_t;

    vec_t tbl [$];

    function automatic int get_cnt(input int k);
        return (k == 0) ? int'(cnt_a) : int'(cnt_b);
    endfunction

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input bit f, input bit v,
                         input logic [15:0] d, input bit r);
        flush[k] = f;
        iv[k]    = v;
        din[k]   = d;
        ordy[k]  = r;
    endtask

    task automatic idle_all();
        drive(0, 0, 0, 16'h0, 0);
        drive(1, 0, 0, 16'h0, 0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_random(input int k);
        logic [15:0] exp_q [$];
        logic [15:0] word;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        bit have = 0;
        bit r;
        bit do_push;
        bit do_pop;
        word = '0;
        while (recv < 1000 && cyc < 20000) begin
            chk("rnd_count", get_cnt(k), exp_q.size());
            if (!have && sent < 1000 && $urandom_range(0, 15) < 8) begin
                have = 1;
                word = 16'($urandom);
            end
            r = $urandom_range(0, 15) < 4;
            do_push = have && ir[k];
            do_pop  = ov[k] && r;
            if (do_pop) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_valid", 1, 0);
                end else begin
                    chk("rnd_data", dout[k], exp_q.pop_front());
                    recv++;
                end
            end
            drive(k, 0, have, word, r);
            if (do_push) begin
                exp_q.push_back(word);
                have = 0;
                sent++;
            end
            step();
            cyc++;
        end
        if (recv < 1000) chk("rnd_timeout_words", recv, 1000);
        idle_all();
        step();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_all();
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        step();

        for (int k = 0; k < 2; k++) begin
            chk("rst_ov", ov[k], 0);
            chk("rst_cnt", get_cnt(k), 0);
            chk("rst_ir", ir[k], 1);
            chk("rst_ae", ae[k], 1);
            chk("rst_af", af[k], 0);
        end
        chk("rst_dout_reg", dout[1], 0);

        // fill, full+pop, drain, simultaneous push/pop on depth 4
        tbl.push_back('{1, 0, 16'h0, 1, 1, 1, 16'h0});
        tbl.push_back('{1, 0, 16'h1, 1, 1, 2, 16'h0});
        tbl.push_back('{1, 0, 16'h2, 1, 1, 3, 16'h0});
        tbl.push_back('{1, 0, 16'h3, 0, 1, 4, 16'h0});
        tbl.push_back('{1, 0, 16'h4, 0, 1, 4, 16'h0});
        tbl.push_back('{1, 0, 16'h5, 0, 1, 4, 16'h0});
        tbl.push_back('{1, 1, 16'h6, 1, 1, 3, 16'h1});
        tbl.push_back('{1, 0, 16'h7, 0, 1, 4, 16'h1});
        tbl.push_back('{0, 1, 16'h0, 1, 1, 3, 16'h2});
        tbl.push_back('{0, 1, 16'h0, 1, 1, 2, 16'h3});
        tbl.push_back('{0, 1, 16'h0, 1, 1, 1, 16'h7});
        tbl.push_back('{0, 1, 16'h0, 1, 0, 0, 16'h0});
        tbl.push_back('{1, 0, 16'h8, 1, 1, 1, 16'h8});
        tbl.push_back('{1, 1, 16'h9, 1, 1, 1, 16'h9});
        tbl.push_back('{0, 1, 16'h0, 1, 0, 0, 16'h0});

        foreach (tbl[i]) begin
            drive(0, 0, tbl[i].v, tbl[i].d, tbl[i].rdy);
            step();
            chk($sformatf("vec%0d_ir", i), ir[0], tbl[i].e_ir);
            chk($sformatf("vec%0d_ov", i), ov[0], tbl[i].e_ov);
            chk($sformatf("vec%0d_cnt", i), get_cnt(0), tbl[i].e_cnt);
            chk($sformatf("vec%0d_af", i), af[0], tbl[i].e_cnt >= 2);
            chk($sformatf("vec%0d_ae", i), ae[0], tbl[i].e_cnt <= 1);
            if (tbl[i].e_ov) begin
                chk($sformatf("vec%0d_dout", i), dout[0], tbl[i].e_dout);
            end
        end
        idle_all();

        // flags on the registered FIFO
        for (int i = 1; i <= 6; i++) begin
            drive(1, 0, 1, 16'(i), 0);
            step();
            chk($sformatf("flag_push%0d_cnt", i), get_cnt(1), i);
            chk($sformatf("flag_push%0d_af", i), af[1], i >= 6);
            chk($sformatf("flag_push%0d_ae", i), ae[1], i <= 1);
        end
        for (int c = 5; c >= 1; c--) begin
            drive(1, 0, 0, 16'h0, 1);
            step();
            chk($sformatf("flag_pop%0d_cnt", c), get_cnt(1), c);
            chk($sformatf("flag_pop%0d_dout", c), dout[1], 7 - c);
            chk($sformatf("flag_pop%0d_ae", c), ae[1], c <= 1);
            chk($sformatf("flag_pop%0d_af", c), af[1], 0);
        end
        step();
        chk("flag_drain_ov", ov[1], 0);
        chk("flag_drain_cnt", get_cnt(1), 0);

        // flush with a concurrent push
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 16'h100 + 16'(i), 0);
            step();
        end
        chk("flush_pre_cnt", get_cnt(1), 5);
        drive(1, 1, 1, 16'hFFFF, 0);
        #1;
        chk("flush_ir", ir[1], 1);
        step();
        chk("flush_cnt", get_cnt(1), 0);
        chk("flush_ov", ov[1], 0);
        drive(1, 0, 1, 16'h2A, 0);
        step();
        drive(1, 0, 0, 16'h0, 0);
        chk("flush_next_ov", ov[1], 1);
        chk("flush_next_dout", dout[1], 16'h2A);
        chk("flush_next_cnt", get_cnt(1), 1);
        drive(1, 0, 0, 16'h0, 1);
        step();
        chk("flush_final_cnt", get_cnt(1), 0);
        chk("flush_final_ov", ov[1], 0);
        idle_all();

        // reset in the middle of traffic
        drive(0, 0, 1, 16'hA1, 0);
        drive(1, 0, 1, 16'hB1, 0);
        step();
        drive(0, 0, 1, 16'hA2, 0);
        drive(1, 0, 1, 16'hB2, 0);
        step();
        chk("mid_pre_cnt_a", get_cnt(0), 2);
        reset_n = 1'b0;
        #1;
        chk("mid_async_ov_a", ov[0], 0);
        chk("mid_async_cnt_b", get_cnt(1), 0);
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_ov", ov[k], 0);
            chk("mid_rst_cnt", get_cnt(k), 0);
            chk("mid_rst_ae", ae[k], 1);
            chk("mid_rst_ir", ir[k], 1);
        end
        idle_all();
        reset_n = 1'b1;
        step();
        chk("mid_after_ov_a", ov[0], 0);
        chk("mid_after_ov_b", ov[1], 0);

        run_random(0);
        run_random(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
